md_sequencer: RTL and testbench

//  E-stage multiply/divide sequencer. Owns the HI/LO registers and models the fixed latency of

---
 rtl/md_sequencer.sv | 154 +++++++++++++++
 tb/tb_md_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO and holds busy for the fixed mult/div latency.
// The result is computed when the op is accepted and committed to HI/LO when the count runs out.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_wr;

  logic             w_is_long;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic [31:0]      w_b_nz;
  logic [31:0]      w_abs_a;
  logic [31:0]      w_abs_b;
  logic [31:0]      w_q_mag;
  logic [31:0]      w_r_mag;
  logic [31:0]      w_q_s;
  logic [31:0]      w_r_s;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_wr;

  assign w_is_long = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                     (md_op == OP_DIV)  || (md_op == OP_DIVU);

  // Products and quotients; a zero divisor is swapped for 1 only to keep the divider defined.
  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_b_nz   = (B == 32'd0) ? 32'd1 : B;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
  assign w_abs_a  = A[31] ? (~A + 32'd1) : A;
  assign w_abs_b  = w_b_nz[31] ? (~w_b_nz + 32'd1) : w_b_nz;
  assign w_q_mag  = w_abs_a / w_abs_b;
  assign w_r_mag  = w_abs_a % w_abs_b;
  assign w_q_s    = (A[31] ^ w_b_nz[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s    = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b0;
    case (md_op)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; w_res_wr = 1'b1; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; w_res_wr = 1'b1; end
      OP_DIV:   begin w_res_hi = w_r_s; w_res_lo = w_q_s; w_res_wr = (B != 32'd0); end
      OP_DIVU:  begin
        w_res_hi = A % w_b_nz;
        w_res_lo = A / w_b_nz;
        w_res_wr = (B != 32'd0);
      end
      default:  ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; starts seen while running are dropped
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && w_is_long) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == '0)        w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counter, pending result, busy and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_long) begin
              r_cnt     <= ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_pend_wr <= w_res_wr;
            end else if (md_op == OP_MTHI) begin
              r_hi <= A;
            end else if (md_op == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign md_out = rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus randomized ops against a
// longint-arithmetic reference of HI/LO and the busy window.
module tb_md_sequencer;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_tests = 0;
  int n_fail  = 0;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .rd_hi(rd_hi), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; returns one cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0; md_op = 3'd0;
  endtask

  // Architectural {hi,lo} after a long op, from the arithmetic definitions.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: begin u = {32'd0, a} * {32'd0, b}; return u; end
      3'd3: begin
        if (b == 32'd0) return old;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return old;
        return {a % b, a / b};
      end
      default: return old;
    endcase
  endfunction

  task automatic test_reset();
    issue(3'd5, $urandom, 32'd0);
    issue(3'd6, $urandom, 32'd0);
    issue(3'd1, $urandom, $urandom);
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rd_hi = 1'b1; #1;
    n_tests++; if (md_out !== 32'd0) begin n_fail++; $display("FAIL reset_mdout got=%h exp=0", md_out); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < int'(MULT_N); i++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy cyc=%0d got=%0b exp=1", i + 1, busy); end
      tick();
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_done_busy got=%0b exp=0", busy); end
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    n_tests++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
  endtask

  task automatic test_multu_div();
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < int'(MULT_N); i++) tick();
    n_tests++; if (hi !== 32'd1) begin n_fail++; $display("FAIL multu_hi got=%h exp=1", hi); end
    n_tests++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < int'(DIV_N); i++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy cyc=%0d got=%0b exp=1", i + 1, busy); end
      tick();
    end
    n_tests++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < int'(DIV_N); i++) tick();
    n_tests++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_div_zero();
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd4, 32'd7, 32'd0);
    for (int i = 0; i < int'(DIV_N); i++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL divz_busy cyc=%0d got=%0b exp=1", i + 1, busy); end
      tick();
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divz_done_busy got=%0b exp=0", busy); end
    n_tests++; if (hi !== 32'h11) begin n_fail++; $display("FAIL divz_hi got=%h exp=11", hi); end
    n_tests++; if (lo !== 32'h22) begin n_fail++; $display("FAIL divz_lo got=%h exp=22", lo); end
  endtask

  task automatic test_ignore_in_run();
    issue(3'd4, 32'd7, 32'd2);
    for (int i = 0; i < int'(DIV_N); i++) begin
      if (i == 2) begin start = 1'b1; md_op = 3'd5; A = 32'h1234; end
      tick();
      start = 1'b0; md_op = 3'd0;
    end
    n_tests++; if (hi !== 32'd1) begin n_fail++; $display("FAIL ign_hi got=%h exp=1", hi); end
    n_tests++; if (lo !== 32'd3) begin n_fail++; $display("FAIL ign_lo got=%h exp=3", lo); end
    issue(3'd6, 32'd9, 32'd0);
    n_tests++; if (lo !== 32'd9) begin n_fail++; $display("FAIL mtlo_lo got=%h exp=9", lo); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got=%0b exp=0", busy); end
    rd_hi = 1'b0; #1;
    n_tests++; if (md_out !== 32'd9) begin n_fail++; $display("FAIL mdout_lo got=%h exp=9", md_out); end
    rd_hi = 1'b1; #1;
    n_tests++; if (md_out !== 32'd1) begin n_fail++; $display("FAIL mdout_hi got=%h exp=1", md_out); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy2 got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    issue(3'd1, 32'd7, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    n_tests++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL abort_hilo got=%h_%h exp=0_0", hi, lo);
    end
    issue(3'd1, 32'd7, 32'd3);
    for (int i = 0; i < int'(MULT_N); i++) tick();
    n_tests++; if (lo !== 32'd21 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got lo=%h busy=%0b exp lo=15 busy=0", lo, busy);
    end
    issue(3'd2, 32'h0001_0000, 32'h0001_0000);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
    for (int i = 1; i < int'(MULT_N); i++) tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_lastbusy got=%0b exp=1", busy); end
    tick();
    n_tests++; if (hi !== 32'd1 || lo !== 32'd0) begin
      n_fail++; $display("FAIL b2b_result got=%h_%h exp=1_0", hi, lo);
    end
  endtask

  task automatic test_random();
    logic [63:0] m;
    logic [2:0]  op;
    logic [31:0] a, b, exp_out;
    int          n;
    m = {hi, lo};
    // Model state starts from the last checked architectural values.
    m = {32'd1, 32'd0};
    for (int it = 0; it < 80; it++) begin
      op = 3'($urandom_range(7, 0));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(5, 0))
        0: b = 32'd0;
        1: b = 32'($urandom_range(9, 1));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(9, 1));
        default: ;
      endcase
      issue(op, a, b);
      if (op >= 3'd1 && op <= 3'd4) begin
        n = (op <= 3'd2) ? int'(MULT_N) : int'(DIV_N);
        m = ref_md(op, a, b, m);
        for (int i = 0; i < n; i++) begin
          n_tests++; if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rnd_busy it=%0d cyc=%0d got=%0b exp=1", it, i + 1, busy);
          end
          if ($urandom_range(2, 0) == 0) begin
            start = 1'b1; md_op = 3'($urandom_range(7, 0)); A = $urandom; B = $urandom;
          end
          tick();
          start = 1'b0; md_op = 3'd0;
        end
      end else if (op == 3'd5) begin
        m[63:32] = a;
      end else if (op == 3'd6) begin
        m[31:0] = a;
      end
      rd_hi = 1'($urandom_range(1, 0)); #1;
      exp_out = rd_hi ? m[63:32] : m[31:0];
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle it=%0d got=%0b exp=0", it, busy); end
      n_tests++; if ({hi, lo} !== m) begin
        n_fail++; $display("FAIL rnd_hilo it=%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h",
                           it, op, a, b, hi, lo, m[63:32], m[31:0]);
      end
      n_tests++; if (md_out !== exp_out) begin
        n_fail++; $display("FAIL rnd_mdout it=%0d got=%h exp=%h", it, md_out, exp_out);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0; rd_hi = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_mult();
    test_multu_div();
    test_div_zero();
    test_ignore_in_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
